// File: rtl/dswb_pkg.sv
// Shared types and default constants for the DSWB sewage return path.
package dswb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TREAT     = 2'd1,
    DISCHARGE = 2'd2
  } plant_state_t;

  localparam int TANK_MAX     = 1000;
  localparam int BATCH_SIZE   = 256;
  localparam int TREAT_CYCLES = 8;
  localparam int RETURN_CHUNK = 32;

  // A quarter of each batch is lost as sludge, leaving a 75% yield.
  localparam int YIELD_SHIFT  = 2;
  localparam logic [8:0] BATCH_YIELD = 9'(BATCH_SIZE - (BATCH_SIZE >> YIELD_SHIFT));

  // Size of the next return beat: a full chunk, or the remainder of the reactor.
  function automatic logic [5:0] chunk_of(input logic [8:0] units);
    return (units > 9'(RETURN_CHUNK)) ? 6'(RETURN_CHUNK) : units[5:0];
  endfunction

endpackage

// File: rtl/sewage_tank.sv
// Holding tank: a saturating accumulator that nets inflow against batch
// withdrawals and keeps a running, saturating tally of spilled sewage.
module sewage_tank
  import dswb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  inflow,
  input  logic [8:0]  withdraw,
  output logic [9:0]  tank_level,
  output logic        tank_overflow,
  output logic [11:0] spilled_total
);

  logic [10:0] next_level;
  logic [10:0] excess;
  logic        over_capacity;
  logic [12:0] spill_sum;

  // Net the cycle's inflow and withdrawal, and work out any excess over capacity.
  always_comb begin
    next_level    = {1'b0, tank_level} + {2'b00, inflow} - {2'b00, withdraw};
    over_capacity = next_level > 11'(TANK_MAX);
    excess        = over_capacity ? (next_level - 11'(TANK_MAX)) : 11'd0;
    spill_sum     = {1'b0, spilled_total} + {2'b00, excess};
  end

  // Register the new level, clamping at capacity and accounting for the spill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tank_level    <= 10'd0;
      tank_overflow <= 1'b0;
      spilled_total <= 12'd0;
    end else if (over_capacity) begin
      tank_level    <= 10'(TANK_MAX);
      tank_overflow <= 1'b1;
      spilled_total <= (spill_sum > 13'd4095) ? 12'd4095 : spill_sum[11:0];
    end else begin
      tank_level    <= next_level[9:0];
      tank_overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/sewage_treatment_plant.sv
// Sewage treatment plant: collects population sewage into a tank, treats it in
// batches and returns the treated water to the reservoir over valid/ready beats.
module sewage_treatment_plant
  import dswb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inflow_en,
  input  logic [7:0]  city_population,
  input  logic [7:0]  town_population,
  input  logic        return_ready,
  output logic        return_valid,
  output logic [5:0]  return_amount,
  output logic [9:0]  tank_level,
  output logic [1:0]  plant_state,
  output logic        tank_overflow,
  output logic [11:0] spilled_total
);

  localparam int CW = $clog2(TREAT_CYCLES);

  plant_state_t    state;
  logic [CW-1:0]   treat_count;
  logic [8:0]      reactor;
  logic [8:0]      pop_sum;
  logic [8:0]      inflow;
  logic [8:0]      withdraw;
  logic            start_batch;
  logic [8:0]      reactor_after;

  // Sewage inflow from the populations and the batch withdrawal on leaving IDLE.
  always_comb begin
    pop_sum       = {1'b0, city_population} + {1'b0, town_population};
    inflow        = inflow_en ? {1'b0, pop_sum[8:1]} : 9'd0;
    start_batch   = (state == IDLE) && (tank_level >= 10'(BATCH_SIZE));
    withdraw      = start_batch ? 9'(BATCH_SIZE) : 9'd0;
    reactor_after = reactor - {3'b000, return_amount};
  end

  sewage_tank u_tank (
    .clk           (clk),
    .reset         (reset),
    .inflow        (inflow),
    .withdraw      (withdraw),
    .tank_level    (tank_level),
    .tank_overflow (tank_overflow),
    .spilled_total (spilled_total)
  );

  // Batch FSM: treat counter, reactor contents and the registered return beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      treat_count   <= '0;
      reactor       <= 9'd0;
      return_valid  <= 1'b0;
      return_amount <= 6'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_batch) begin
            treat_count <= CW'(TREAT_CYCLES - 1);
            state       <= TREAT;
          end
        end
        TREAT: begin
          if (treat_count == '0) begin
            reactor       <= BATCH_YIELD;
            return_valid  <= 1'b1;
            return_amount <= chunk_of(BATCH_YIELD);
            state         <= DISCHARGE;
          end else begin
            treat_count <= treat_count - 1'b1;
          end
        end
        DISCHARGE: begin
          if (return_valid && return_ready) begin
            reactor <= reactor_after;
            if (reactor_after == 9'd0) begin
              return_valid  <= 1'b0;
              return_amount <= 6'd0;
              state         <= IDLE;
            end else begin
              return_amount <= chunk_of(reactor_after);
            end
          end
        end
        default: begin
          state         <= IDLE;
          return_valid  <= 1'b0;
          return_amount <= 6'd0;
        end
      endcase
    end
  end

  assign plant_state = state;

endmodule
